// File: rtl/blink_rate_scheduler.sv
// blink_rate_scheduler
//   Arbitrates among five blink-rate requests, runs the half-period counter
//   for the granted rate and toggles a single blink state. Supports pause or
//   resume, and restarts the count cleanly whenever the grant changes.
//
//   Ports:
//     CLOCK_50  in   system clock (rising edge)
//     reset     in   asynchronous, active-high reset
//     req[4:0]  in   level rate requests; bit i requests rate i
//     pause     in   level; freezes blinking while high
//     blink     out  registered blink state
//     tick      out  registered one-cycle pulse on every blink toggle
//     active    out  granted rate index 0..4, 7 = none
//     busy      out  high in RUN or PAUSED
//
//   Optional feature macro: BLINK_ROTATE_EN
//     When defined, the grant rotates among the set request bits every
//     ROTATE_TOGGLES toggles. When undefined, the lowest set bit always wins
//     and no rotation logic is built.
module blink_rate_scheduler #(
  parameter int unsigned HALF_UNIT      = 25000000,
  parameter int unsigned ROTATE_TOGGLES = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [4:0] req,
  input  logic       pause,
  output logic       blink,
  output logic       tick,
  output logic [2:0] active,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED} state_t;
  localparam logic [2:0] NONE = 3'd7;

  if (ROTATE_TOGGLES < 1 || ROTATE_TOGGLES > 15) begin : g_bad_rot
    $error("ROTATE_TOGGLES must be 1..15");
  end

  state_t      state_q, state_d;
  logic [27:0] cnt_q, cnt_d;
  logic        blink_q, blink_d;
  logic        tick_q, tick_d;
  logic [2:0]  active_q, active_d;
  logic        busy_q, busy_d;
  logic [2:0]  grant;
  logic [27:0] lim_m1;

  // Half-period in cycles for a rate index: HALF_UNIT * {1,2,4,6,8}.
  function automatic logic [27:0] half_len(input logic [2:0] idx);
    logic [27:0] m;
    case (idx)
      3'd0:    m = 28'd1;
      3'd1:    m = 28'd2;
      3'd2:    m = 28'd4;
      3'd3:    m = 28'd6;
      3'd4:    m = 28'd8;
      default: m = 28'd1;
    endcase
    return 28'(HALF_UNIT) * m;
  endfunction

  // Terminal count is taken from the registered grant, not the live one.
  assign lim_m1 = half_len(active_q) - 28'd1;

`ifdef BLINK_ROTATE_EN
  logic [3:0] rot_q, rot_d;
  logic       held;

  // First set bit strictly above a, wrapping 4 -> 0; a itself is the last
  // candidate. With a = NONE the search starts at 0 (lowest set bit).
  function automatic logic [2:0] next_up(input logic [4:0] r, input logic [2:0] a);
    logic [2:0] g;
    int         base;
    g    = NONE;
    base = (a > 3'd4) ? 4 : int'(a);
    // Walk candidates farthest-first so the nearest one overwrites last.
    for (int k = 5; k >= 1; k--) begin
      if (r[(base + k) % 5]) g = 3'((base + k) % 5);
    end
    return g;
  endfunction

  assign held = (active_q <= 3'd4) && req[active_q];

  always_comb begin
    if (!held)
      grant = next_up(req, active_q);
    else if (rot_q >= 4'(ROTATE_TOGGLES))
      grant = next_up(req, active_q);  // returns active_q when it is alone
    else
      grant = active_q;
  end
`else
  always_comb begin
    casez (req)
      5'b????1: grant = 3'd0;
      5'b???10: grant = 3'd1;
      5'b??100: grant = 3'd2;
      5'b?1000: grant = 3'd3;
      5'b10000: grant = 3'd4;
      default:  grant = NONE;
    endcase
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    blink_d  = blink_q;
    tick_d   = 1'b0;
    active_d = active_q;
    busy_d   = busy_q;
`ifdef BLINK_ROTATE_EN
    rot_d    = rot_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d    = '0;
        blink_d  = 1'b0;
        active_d = NONE;
        busy_d   = 1'b0;
        if (req != 5'd0) begin
          state_d  = S_RUN;
          active_d = grant;
          busy_d   = 1'b1;
        end
      end
      default: begin  // S_RUN, S_PAUSED
        if (req == 5'd0) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          blink_d  = 1'b0;
          active_d = NONE;
          busy_d   = 1'b0;
`ifdef BLINK_ROTATE_EN
          rot_d    = '0;
`endif
        end else if (pause) begin
          // Frozen: counter stays where it is, even at L-1.
          state_d = S_PAUSED;
        end else begin
          // The resume edge itself counts, so no cycle is lost or gained.
          state_d = S_RUN;
          if (grant != active_q) begin
            active_d = grant;
            cnt_d    = '0;
`ifdef BLINK_ROTATE_EN
            rot_d    = '0;
`endif
          end else if (cnt_q == lim_m1) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
            tick_d  = 1'b1;
`ifdef BLINK_ROTATE_EN
            if (rot_q < 4'(ROTATE_TOGGLES)) rot_d = rot_q + 4'd1;
`endif
          end else begin
            cnt_d = cnt_q + 28'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      blink_q  <= 1'b0;
      tick_q   <= 1'b0;
      active_q <= NONE;
      busy_q   <= 1'b0;
`ifdef BLINK_ROTATE_EN
      rot_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      blink_q  <= blink_d;
      tick_q   <= tick_d;
      active_q <= active_d;
      busy_q   <= busy_d;
`ifdef BLINK_ROTATE_EN
      rot_q    <= rot_d;
`endif
    end
  end

  assign blink  = blink_q;
  assign tick   = tick_q;
  assign active = active_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_blink_rate_scheduler.sv
// Self-checking bench for blink_rate_scheduler (HALF_UNIT = 4,
// ROTATE_TOGGLES = 2): half-periods are 4, 8, 16, 24, 32 cycles.
module tb_blink_rate_scheduler;
  localparam int HU = 4;
  localparam int RT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req;
  logic       pause;
  logic       blink, tick, busy;
  logic [2:0] active;

  int n_tests = 0;
  int n_fail  = 0;

  blink_rate_scheduler #(.HALF_UNIT(HU), .ROTATE_TOGGLES(RT)) dut (
    .CLOCK_50(clk), .reset(rst), .req(req), .pause(pause),
    .blink(blink), .tick(tick), .active(active), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] req;
    logic       pause;
    int         ncyc;
    logic [2:0] act;
    logic       bsy;
    logic       blk;
    int         ticks;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [4:0] r, input logic p, input int n, input logic [2:0] a,
                     input logic b, input logic bl, input int t);
    vec_t v;
    v.req = r; v.pause = p; v.ncyc = n; v.act = a; v.bsy = b; v.blk = bl; v.ticks = t;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 5'd0; pause = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v, e;
    int   tcnt;

    // {req, pause, cycles, active, busy, blink, ticks in window}
    add(5'b00000, 0,  3, 3'd7, 0, 0, 0);
    add(5'b00001, 0,  1, 3'd0, 1, 0, 0);  // E0: granted, counter 0
    add(5'b00001, 0,  4, 3'd0, 1, 1, 1);  // first toggle at E0+4
    add(5'b00001, 0,  8, 3'd0, 1, 1, 2);  // tick every 4
    add(5'b00000, 0,  1, 3'd7, 0, 0, 0);  // back to IDLE
    add(5'b00110, 0,  1, 3'd1, 1, 0, 0);
    add(5'b00110, 0, 16, 3'd1, 1, 0, 2);  // tick every 8
    add(5'b00100, 0,  1, 3'd2, 1, 0, 0);  // grant change, no tick
    add(5'b00100, 0, 16, 3'd2, 1, 1, 1);
    add(5'b00100, 1,  5, 3'd2, 1, 1, 0);  // paused, frozen
    add(5'b01000, 1,  3, 3'd2, 1, 1, 0);  // no re-arbitration while paused
    add(5'b01000, 0,  1, 3'd3, 1, 1, 0);  // resume sees a grant change
    add(5'b01000, 0, 24, 3'd3, 1, 0, 1);
    add(5'b00000, 1,  1, 3'd7, 0, 0, 0);  // req = 0 beats pause

    rst = 1'b1; req = 5'd0; pause = 1'b0;
    #12;
    chk("reset_active", 32'(active), 32'd7);
    chk("reset_busy",   32'(busy),   32'd0);
    chk("reset_blink",  32'(blink),  32'd0);
    chk("reset_tick",   32'(tick),   32'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      v = tbl[i];
      req = v.req; pause = v.pause;
      sb.push_back(v);
      tcnt = 0;
      for (int c = 0; c < v.ncyc; c++) begin
        step();
        if (tick === 1'b1) tcnt++;
      end
      e = sb.pop_front();
      chk($sformatf("vec%0d_active", i), 32'(active), 32'(e.act));
      chk($sformatf("vec%0d_busy", i),   32'(busy),   32'(e.bsy));
      chk($sformatf("vec%0d_blink", i),  32'(blink),  32'(e.blk));
      chk($sformatf("vec%0d_ticks", i),  32'(tcnt),   32'(e.ticks));
    end

    // Lower-index request arrives mid-count at counter = 5.
    do_reset();
    req = 5'b00110;
    step();
    for (int c = 0; c < 5; c++) step();
    req = 5'b00111;
    step();
    chk("midcount_active", 32'(active), 32'd0);
    chk("midcount_tick",   32'(tick),   32'd0);
    chk("midcount_blink",  32'(blink),  32'd0);
    tcnt = 0;
    for (int c = 0; c < 3; c++) begin step(); if (tick) tcnt++; end
    chk("midcount_noearly", 32'(tcnt), 32'd0);
    step();
    chk("midcount_tick4", 32'(tick), 32'd1);

    // Pause at counter = 2 for 10 cycles.
    do_reset();
    req = 5'b00001;
    step();
    step(); step();
    pause = 1'b1;
    tcnt = 0;
    for (int c = 0; c < 10; c++) begin step(); if (tick) tcnt++; end
    chk("pause_ticks", 32'(tcnt),  32'd0);
    chk("pause_blink", 32'(blink), 32'd0);
    chk("pause_busy",  32'(busy),  32'd1);
    pause = 1'b0;
    step();
    chk("resume_c3_tick", 32'(tick), 32'd0);
    step();
    chk("resume_tick",  32'(tick),  32'd1);
    chk("resume_blink", 32'(blink), 32'd1);

    // Pause exactly at terminal count.
    step(); step(); step();
    pause = 1'b1;
    tcnt = 0;
    for (int c = 0; c < 4; c++) begin step(); if (tick) tcnt++; end
    chk("pause_tc_ticks", 32'(tcnt),  32'd0);
    chk("pause_tc_blink", 32'(blink), 32'd1);
    pause = 1'b0;
    step();
    chk("resume_tc_tick",  32'(tick),  32'd1);
    chk("resume_tc_blink", 32'(blink), 32'd0);

    // req drops while PAUSED.
    step(); step();
    pause = 1'b1;
    step();
    req = 5'd0;
    step();
    chk("pdrop_active", 32'(active), 32'd7);
    chk("pdrop_busy",   32'(busy),   32'd0);
    chk("pdrop_blink",  32'(blink),  32'd0);

    // Asynchronous reset mid-RUN with blink = 1 and tick high.
    do_reset();
    req = 5'b00001;
    step();
    for (int c = 0; c < 4; c++) step();
    chk("prereset_blink", 32'(blink), 32'd1);
    chk("prereset_tick",  32'(tick),  32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_blink",  32'(blink),  32'd0);
    chk("async_tick",   32'(tick),   32'd0);
    chk("async_active", 32'(active), 32'd7);
    chk("async_busy",   32'(busy),   32'd0);
    step();
    rst = 1'b0;

    // Two requests 0 and 4.
    do_reset();
    req = 5'b10001;
    step();
`ifdef BLINK_ROTATE_EN
    chk("rot_first", 32'(active), 32'd0);
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("rot_hold0_c%0d", c), 32'(active), 32'd0);
    end
    step();
    chk("rot_to4",      32'(active), 32'd4);
    chk("rot_to4_tick", 32'(tick),   32'd0);
    tcnt = 0;
    for (int c = 0; c < 64; c++) begin step(); if (tick) tcnt++; end
    chk("rot4_ticks",  32'(tcnt),   32'd2);
    chk("rot4_active", 32'(active), 32'd4);
    step();
    chk("rot_back0", 32'(active), 32'd0);
    for (int c = 0; c < 9; c++) step();
    chk("rot_again4", 32'(active), 32'd4);
    req = 5'b00001;
    step();
    chk("rot_drop4", 32'(active), 32'd0);
`else
    for (int c = 0; c < 100; c++) begin
      step();
      if (c % 10 == 0) chk($sformatf("fixed_c%0d", c), 32'(active), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
